incr_ctrl: RTL and testbench
============================

INCR_CTRL -- requirements
Module: incr_ctrl

Interface
REQ-001 Parameter PC_W, default 4, sets the program-counter width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begins program execution from pc=0; sampled only in IDLE.
REQ-005 instr_valid  input  1  instruction-source handshake valid.
REQ-006 instruct  input  2  opcode: 00 HALT, 01 INC, 10 JNO, 11 CLR.
REQ-007 jump_target  input  PC_W  JNO destination; captured with instruct.
REQ-008 instr_ready  output  1  controller accepts an instruction this cycle.
REQ-009 pc  output  PC_W  address of the instruction being requested.
REQ-010 value  output  2  accumulator register under control.
REQ-011 sta  output  1  carry-out of the most recent INC.
REQ-012 mn  output  1  high for the EXEC cycle of a HALT opcode.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on program completion.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, EXEC and DONE.
REQ-016 IDLE: on start=1, the next state is FETCH, with pc, value and sta cleared on that edge; otherwise it stays in IDLE.
REQ-017 FETCH: instr_ready=1; on instr_valid=1, instruct and jump_target are latched and the next state is EXEC; otherwise it holds in FETCH indefinitely.
REQ-018 instr_ready SHALL be 0 in all states other than FETCH; instr_valid outside FETCH is ignored.
REQ-019 EXEC lasts exactly one cycle.
  - INC: value <= value+1 mod 4, sta <= carry-out, pc <= pc+1; next state FETCH.
  - CLR: value <= 0, sta <= 0, pc <= pc+1; next state FETCH.
  - JNO: if sta=0 then pc <= target, else pc <= pc+1; value and sta unchanged; next state FETCH.
  - HALT: mn=1, pc/value/sta unchanged; next state DONE.
REQ-020 Only INC and CLR SHALL write sta; sta holds its value across JNO and HALT.
REQ-021 pc+1 SHALL wrap from 2^PC_W-1 to 0 without any flag.
REQ-022 INC with value=3 SHALL yield value=0 and sta=1.
REQ-023 Instruction throughput SHALL be 2 cycles per instruction when instr_valid is held high.
REQ-024 DONE: done=1 for exactly one cycle; the next state is IDLE, and value/sta remain readable.
REQ-025 start asserted in any state other than IDLE SHALL be ignored.
REQ-026 mn SHALL be combinational from the latched opcode, qualified by state EXEC; all other outputs are registered.

Reset
REQ-027 rst=1 SHALL asynchronously force state to IDLE and drive pc=0, value=0, sta=0, done=0, mn=0, busy=0 and instr_ready=0.
REQ-028 rst asserted mid-program SHALL abort the program with no done pulse; after rst deasserts, the block waits in IDLE for start.

Structure
REQ-029 The shared package incr_pkg SHALL hold the opcode constants (OP_HALT, OP_INC, OP_JNO, OP_CLR) and the state encoding.
REQ-030 The increment SHALL be computed by instantiating the team's two-bit adder sub-module fulladder, with its carry driving the next value of sta.

Verification
REQ-031 Reset mid-EXEC of an INC -> all outputs zero immediately, state IDLE, no done pulse.
REQ-032 start; program INC,INC,INC,INC,HALT -> value 1,2,3,0 and sta 0,0,0,1; mn pulses once, done pulses once, pc=4 at done.
REQ-033 start; program CLR,INC,JNO(target=7) -> sta=0 so pc=7 after JNO; INC with value=3 followed by JNO(target=7) -> pc increments, no jump.
REQ-034 instr_valid held low for 10 cycles in FETCH -> instr_ready stays 1, pc and value unchanged; an instruction is accepted on the first valid.
REQ-035 PC_W=4, pc=15, INC -> pc=0; start pulsed while busy -> no effect on pc or value.
REQ-036 HALT as the first instruction -> value=0, sta=0, done pulses 2 cycles after acceptance, busy low the following cycle.

Source files
------------

// File: rtl/incr_pkg.sv
// incr_pkg -- shared definitions for the incr_ctrl instruction sequencer.
//   OP_*    : two-bit opcode encoding presented on instruct
//   state_t : controller state encoding
package incr_pkg;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_JNO  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/incr_ctrl_fulladder.sv
// fulladder -- two-bit ripple adder with carry-in and carry-out.
//   a, b  : two-bit addends
//   cin   : carry-in
//   sum   : two-bit sum
//   cout  : carry-out of the top bit
module fulladder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] sum,
  output logic       cout
);

  logic c0;

  assign sum[0] = a[0] ^ b[0] ^ cin;
  assign c0     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
  assign sum[1] = a[1] ^ b[1] ^ c0;
  assign cout   = (a[1] & b[1]) | (c0 & (a[1] ^ b[1]));

endmodule

// File: rtl/incr_ctrl.sv
// incr_ctrl -- four-state sequencer (IDLE/FETCH/EXEC/DONE) that fetches
// two-bit opcodes over a valid/ready handshake and applies them to a
// two-bit accumulator.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : launches a program from pc=0 (only honoured in IDLE)
//   instr_valid  : instruction source has an instruction on instruct/jump_target
//   instruct     : opcode (HALT/INC/JNO/CLR)
//   jump_target  : JNO destination
//   instr_ready  : high while waiting for an instruction (FETCH)
//   pc           : address of the instruction being requested
//   value        : accumulator
//   sta          : carry-out of the most recent INC (cleared by CLR)
//   mn           : high during the EXEC cycle of a HALT
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse when a program completes
module incr_ctrl
  import incr_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            instr_valid,
  input  logic [1:0]      instruct,
  input  logic [PC_W-1:0] jump_target,
  output logic            instr_ready,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      value,
  output logic            sta,
  output logic            mn,
  output logic            busy,
  output logic            done
);

  state_t          state;
  logic [1:0]      op_p0;
  logic [PC_W-1:0] tgt_p0;
  logic [1:0]      inc_sum;
  logic            inc_cout;
  logic [PC_W-1:0] pc_next;

  fulladder u_add (
    .a    (value),
    .b    (2'b01),
    .cin  (1'b0),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  // Wraps silently at 2^PC_W.
  assign pc_next = pc + PC_W'(1);

  // Only combinational output: decoded from the latched opcode.
  assign mn = (state == ST_EXEC) && (op_p0 == OP_HALT);

  // Fetch stage: instruction capture (data only, no reset needed since
  // every use is qualified by state).
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && instr_valid) begin
      op_p0  <= instruct;
      tgt_p0 <= jump_target;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      value       <= 2'b00;
      sta         <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instr_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_FETCH;
            pc          <= '0;
            value       <= 2'b00;
            sta         <= 1'b0;
            busy        <= 1'b1;
            instr_ready <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (instr_valid) begin
            state       <= ST_EXEC;
            instr_ready <= 1'b0;
          end
        end
        ST_EXEC: begin
          state       <= ST_FETCH;
          instr_ready <= 1'b1;
          case (op_p0)
            OP_INC: begin
              value <= inc_sum;
              sta   <= inc_cout;
              pc    <= pc_next;
            end
            OP_CLR: begin
              value <= 2'b00;
              sta   <= 1'b0;
              pc    <= pc_next;
            end
            OP_JNO: begin
              // Jump only when the last INC did not carry out.
              pc <= sta ? pc_next : tgt_p0;
            end
            default: begin
              state       <= ST_DONE;
              instr_ready <= 1'b0;
              done        <= 1'b1;
            end
          endcase
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_incr_ctrl.sv
// tb_incr_ctrl -- self-checking bench for incr_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge; a reference model pushes the
// expected architectural state for each accepted instruction, popped once
// the EXEC cycle has completed.
module tb_incr_ctrl;

  localparam int PC_W = 4;
  localparam logic [1:0] HALT = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] JNO  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            instr_valid;
  logic [1:0]      instruct;
  logic [PC_W-1:0] jump_target;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [1:0]      value;
  logic            sta;
  logic            mn;
  logic            busy;
  logic            done;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [1:0]      val;
    logic            sta;
  } exp_t;

  exp_t q[$];

  logic [PC_W-1:0] m_pc;
  logic [1:0]      m_val;
  logic            m_sta;

  int n_cmp = 0;
  int n_err = 0;

  incr_ctrl #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr_valid (instr_valid),
    .instruct    (instruct),
    .jump_target (jump_target),
    .instr_ready (instr_ready),
    .pc          (pc),
    .value       (value),
    .sta         (sta),
    .mn          (mn),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Pulse start from IDLE; leaves the bench at a falling edge in FETCH.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = '0; m_val = 2'b00; m_sta = 1'b0;
    n_cmp++;
    if ({busy, instr_ready, pc, value, sta} !== {1'b1, 1'b1, 4'd0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL start_state got busy=%b rdy=%b pc=%0d val=%0d sta=%b exp busy=1 rdy=1 pc=0 val=0 sta=0",
               busy, instr_ready, pc, value, sta);
    end
  endtask

  // Present one instruction in FETCH and check its EXEC and its result.
  task automatic exec_instr(input logic [1:0] op, input logic [PC_W-1:0] tgt, input bit hold);
    exp_t e;
    logic [2:0] s;
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_ready got=%b exp=1", instr_ready);
    end
    instruct = op; jump_target = tgt; instr_valid = 1'b1;
    case (op)
      INC: begin
        s = {1'b0, m_val} + 3'd1;
        m_val = s[1:0]; m_sta = s[2]; m_pc = m_pc + 4'd1;
      end
      CLR: begin
        m_val = 2'b00; m_sta = 1'b0; m_pc = m_pc + 4'd1;
      end
      JNO: m_pc = (m_sta == 1'b0) ? tgt : m_pc + 4'd1;
      default: ;
    endcase
    e.pc = m_pc; e.val = m_val; e.sta = m_sta;
    q.push_back(e);
    @(negedge clk);
    if (!hold || op == HALT) instr_valid = 1'b0;
    n_cmp++;
    if ({mn, instr_ready, busy} !== {(op == HALT), 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL exec_cycle op=%0d got mn=%b rdy=%b busy=%b exp mn=%b rdy=0 busy=1",
               op, mn, instr_ready, busy, (op == HALT));
    end
    @(negedge clk);
    e = q.pop_front();
    n_cmp++;
    if ({pc, value, sta} !== {e.pc, e.val, e.sta}) begin
      n_err++;
      $display("FAIL result op=%0d got pc=%0d val=%0d sta=%b exp pc=%0d val=%0d sta=%b",
               op, pc, value, sta, e.pc, e.val, e.sta);
    end
    n_cmp++;
    if ({done, instr_ready} !== {(op == HALT), (op != HALT)}) begin
      n_err++;
      $display("FAIL after_exec op=%0d got done=%b rdy=%b exp done=%b rdy=%b",
               op, done, instr_ready, (op == HALT), (op != HALT));
    end
  endtask

  // Cycle after the done pulse: back in IDLE with results still visible.
  task automatic check_idle_after_done();
    @(negedge clk);
    n_cmp++;
    if ({done, busy, instr_ready, mn, pc, value, sta} !== {1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_val, m_sta}) begin
      n_err++;
      $display("FAIL post_done got done=%b busy=%b rdy=%b mn=%b pc=%0d val=%0d sta=%b exp 0 0 0 0 pc=%0d val=%0d sta=%b",
               done, busy, instr_ready, mn, pc, value, sta, m_pc, m_val, m_sta);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instruct = 2'b00; jump_target = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({instr_ready, pc, value, sta, mn, busy, done} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b pc=%0d val=%0d sta=%b mn=%b busy=%b done=%b exp all 0",
               instr_ready, pc, value, sta, mn, busy, done);
    end
    rst = 1'b0;
    // instr_valid outside FETCH must not start anything.
    instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    instr_valid = 1'b0;
    n_cmp++;
    if ({busy, instr_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_hold got busy=%b rdy=%b exp 0 0", busy, instr_ready);
    end
  endtask

  task automatic test_inc_halt();
    do_start();
    repeat (4) exec_instr(INC, 4'd0, 1'b0);
    exec_instr(HALT, 4'd0, 1'b0);
    n_cmp++;
    if ({pc, value, sta} !== {4'd4, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL inc_halt_final got pc=%0d val=%0d sta=%b exp pc=4 val=0 sta=1", pc, value, sta);
    end
    check_idle_after_done();
  endtask

  task automatic test_jno();
    do_start();
    exec_instr(CLR, 4'd0, 1'b0);
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(JNO, 4'd7, 1'b0);
    n_cmp++;
    if (pc !== 4'd7) begin
      n_err++;
      $display("FAIL jno_taken got pc=%0d exp pc=7", pc);
    end
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(JNO, 4'd7, 1'b0);
    n_cmp++;
    if ({pc, sta} !== {4'd11, 1'b1}) begin
      n_err++;
      $display("FAIL jno_not_taken got pc=%0d sta=%b exp pc=11 sta=1", pc, sta);
    end
    exec_instr(HALT, 4'd0, 1'b0);
    check_idle_after_done();
  endtask

  task automatic test_stall();
    int bad = 0;
    do_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({instr_ready, pc, value} !== {1'b1, 4'd0, 2'd0}) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold got %0d bad cycles rdy=%b pc=%0d val=%0d exp 0 bad cycles",
               bad, instr_ready, pc, value);
    end
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(HALT, 4'd0, 1'b0);
    check_idle_after_done();
  endtask

  task automatic test_wrap_start();
    do_start();
    exec_instr(JNO, 4'd15, 1'b0);
    exec_instr(INC, 4'd0, 1'b0);
    exec_instr(JNO, 4'd15, 1'b0);
    // start while busy in FETCH must not clear pc/value.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({pc, value, instr_ready} !== {4'd15, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL start_ignored got pc=%0d val=%0d rdy=%b exp pc=15 val=1 rdy=1", pc, value, instr_ready);
    end
    start = 1'b1;
    exec_instr(INC, 4'd0, 1'b0);
    start = 1'b0;
    n_cmp++;
    if ({pc, value} !== {4'd0, 2'd2}) begin
      n_err++;
      $display("FAIL pc_wrap got pc=%0d val=%0d exp pc=0 val=2", pc, value);
    end
    exec_instr(HALT, 4'd0, 1'b0);
    check_idle_after_done();
  endtask

  task automatic test_halt_first();
    do_start();
    exec_instr(HALT, 4'd0, 1'b0);
    n_cmp++;
    if ({value, sta, busy} !== {2'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL halt_first got val=%0d sta=%b busy=%b exp val=0 sta=0 busy=1", value, sta, busy);
    end
    check_idle_after_done();
  endtask

  task automatic test_back_to_back();
    do_start();
    exec_instr(INC, 4'd0, 1'b1);
    exec_instr(INC, 4'd0, 1'b1);
    exec_instr(CLR, 4'd0, 1'b1);
    exec_instr(INC, 4'd0, 1'b1);
    exec_instr(JNO, 4'd9, 1'b1);
    exec_instr(INC, 4'd0, 1'b1);
    exec_instr(HALT, 4'd0, 1'b1);
    check_idle_after_done();
  endtask

  task automatic test_reset_mid_exec();
    int bad = 0;
    do_start();
    instruct = INC; jump_target = '0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({instr_ready, pc, value, sta, mn, busy, done} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_mid_exec got rdy=%b pc=%0d val=%0d sta=%b mn=%b busy=%b done=%b exp all 0",
               instr_ready, pc, value, sta, mn, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({done, busy, instr_ready} !== 3'b000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_abort got %0d bad cycles exp 0 (no done, stays idle)", bad);
    end
  endtask

  initial begin
    test_reset();
    test_inc_halt();
    test_jno();
    test_stall();
    test_wrap_start();
    test_halt_first();
    test_back_to_back();
    test_reset_mid_exec();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d left exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
